// File: rtl/booth_mul.sv
// Sequential radix-2 Booth multiplier for the RV32M multiply group (full 2*XLEN product).
// Optional: define BOOTH_MUL_ZERO_BYPASS_EN to finish zero-operand requests in one edge.
package core_config_pkg;
  localparam int XLEN = 32;
endpackage

module booth_mul #(
  parameter int XLEN = core_config_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            multiplicand_signed,
  input  logic            multiplier_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] product_hi,
  output logic [XLEN-1:0] product_lo
);
  localparam int CW = $clog2(XLEN+2);
  localparam int SW = 2*XLEN+4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MULT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN:0]   m_q, m_d;
  logic [XLEN+1:0] ac_q, ac_d;
  logic [XLEN:0]   qr_q, qr_d;
  logic            qm1_q, qm1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] phi_q, phi_d, plo_q, plo_d;

  logic [XLEN+1:0] m_sx, acc;
  logic [SW-1:0]   sh;

  // One extra bit per operand lets the signed datapath cover unsigned operands too.
  assign m_sx = {m_q[XLEN], m_q};

  always_comb begin
    acc = ac_q;
    case ({qr_q[0], qm1_q})
      2'b01:   acc = ac_q + m_sx;
      2'b10:   acc = ac_q - m_sx;
      default: acc = ac_q;
    endcase
  end

  // Arithmetic right shift of {AC, QR, Q-1}; the old Q-1 falls off the end.
  assign sh = {acc[XLEN+1], acc, qr_q};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    ac_d    = ac_q;
    qr_d    = qr_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      IDLE: begin
`ifdef BOOTH_MUL_ZERO_BYPASS_EN
        if (start && (multiplicand == '0 || multiplier == '0)) begin
          phi_d   = '0;
          plo_d   = '0;
          valid_d = 1'b1;
        end else
`endif
        if (start) begin
          m_d     = {multiplicand_signed & multiplicand[XLEN-1], multiplicand};
          qr_d    = {multiplier_signed & multiplier[XLEN-1], multiplier};
          ac_d    = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = MULT;
        end
      end
      MULT: begin
        ac_d  = sh[SW-1:XLEN+2];
        qr_d  = sh[XLEN+1:1];
        qm1_d = sh[0];
        cnt_d = cnt_q + 1'b1;
        // XLEN+1 iterations for XLEN+1-bit operands; this edge is the last one.
        if (cnt_q == CW'(XLEN)) begin
          {phi_d, plo_d} = sh[2*XLEN:1];
          valid_d        = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      ac_q    <= '0;
      qr_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      ac_q    <= ac_d;
      qr_q    <= qr_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign busy       = (state_q == MULT);
  assign valid      = valid_q;
  assign product_hi = phi_q;
  assign product_lo = plo_q;
endmodule

// File: tb/tb_booth_mul.sv
// Scoreboard bench for booth_mul: expected products/latencies queued at issue, checked on valid.
module tb_booth_mul;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mcs = 1'b0, mrs = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, valid;
  logic [31:0] hi, lo;
  int          total = 0, bad = 0, cyc = 0;

`ifdef BOOTH_MUL_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  booth_mul dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand_signed(mcs), .multiplier_signed(mrs),
    .multiplicand(a), .multiplier(b),
    .busy(busy), .valid(valid), .product_hi(hi), .product_lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input bit sx, input bit sy);
    logic signed [64:0] ex, ey, p;
    ex = sx ? {{33{x[31]}}, x} : {33'b0, x};
    ey = sy ? {{33{y[31]}}, y} : {33'b0, y};
    p  = ex * ey;
    return p[63:0];
  endfunction

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic drive(input logic [31:0] x, input logic [31:0] y, input bit sx, input bit sy,
                       input logic [63:0] exp, input bit push);
    exp_t e;
    a = x; b = y; mcs = sx; mrs = sy; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; mcs = ~sx; mrs = ~sy;
    if (push) begin
      e.prod = exp;
      e.cyc  = cyc + ((ZB && (x == 0 || y == 0)) ? 0 : 33);
      sb.push_back(e);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || valid) && n < 100);
    if (busy || valid) chk("timeout", 1, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      if (sb.size() == 0) chk("unexp_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("product", {hi, lo}, e.prod);
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int n;
    logic [31:0] x, y;
    bit sx, sy;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_prod", {hi, lo}, 0);
    rst_n = 1'b1;

    drive(32'hFFFFFFFD, 32'd7, 1, 1, 64'hFFFFFFFF_FFFFFFEB, 1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("busy_len", 64'(n), 33);
    wait_ready();

    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE_00000001, 1); wait_ready();
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 64'h00000000_00000001, 1); wait_ready();
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFF_00000001, 1); wait_ready();
    drive(32'h80000000, 32'h80000000, 1, 1, 64'h40000000_00000000, 1); wait_ready();

    // second start mid-operation must be dropped
    drive(32'd6, 32'd7, 1, 1, 64'd42, 1);
    repeat (9) @(negedge clk);
    a = 32'd2; b = 32'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignore", busy, 1);
    n = 0;
    while (!valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", valid, 1);
    drive(32'd2, 32'd3, 1, 1, 64'd6, 1);
    wait_ready();

    // reset in the middle of an operation
    drive(32'd5, 32'd5, 1, 1, 64'd25, 0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_prod", {hi, lo}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(32'd5, 32'd5, 1, 1, 64'd25, 1);
    wait_ready();

    drive(32'd0, 32'h12345678, 1, 1, 64'd0, 1);
    chk("zero_busy", busy, ZB ? 0 : 1);
    wait_ready();

    for (int i = 0; i < 10; i++) begin
      x  = $urandom;
      y  = (i == 3) ? 32'd0 : $urandom;
      sx = 1'($urandom);
      sy = 1'($urandom);
      drive(x, y, sx, sy, ref_mul(x, y, sx, sy), 1);
      wait_ready();
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
